// File: rtl/pipeline_ctrl.sv
// Hazard and pipeline-control unit for the in-order core.
// Stage 0=IF, 1=ID, 2=EX, 3..NUM_STAGES-1 memory/writeback; boundary b sits
// between stage b and stage b+1.
//
// Bus-wait FSM
//   state     | meaning
//   BUS_IDLE  | no bus wait in progress; a fresh BUS_REQ stalls with zero latency
//   BUS_WAIT  | transaction outstanding, watchdog counting down
//   BUS_ABORT | watchdog expired; stall released until BUS_REQ drops
module pipeline_ctrl #(
   parameter int NUM_STAGES       = 5,
   parameter int AW               = 5,
   parameter int BUS_STAGE        = 3,
   parameter int LOAD_READY_STAGE = 4,
   parameter int WDOG_W           = 8,
   parameter int WDOG_LIMIT       = 200,
   localparam int SELW            = $clog2(NUM_STAGES)
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [AW-1:0]            ID_RS1_ADDR,
   input  logic [AW-1:0]            ID_RS2_ADDR,
   input  logic [AW-1:0]            ID_RD_ADDR,
   input  logic                     ID_RD_WE,
   input  logic [AW-1:0]            EX_RS1_ADDR,
   input  logic [AW-1:0]            EX_RS2_ADDR,
   input  logic [NUM_STAGES*AW-1:0] PIPE_RD_ADDR,
   input  logic [NUM_STAGES-1:0]    PIPE_RD_WE,
   input  logic [NUM_STAGES-1:0]    PIPE_IS_LOAD,
   input  logic [NUM_STAGES-1:0]    PIPE_TRAP_VALID,
   input  logic                     EX_IS_PC_REDIRECT,
   input  logic                     MD_ISSUE,
   input  logic                     MD_DONE,
   input  logic [AW-1:0]            MD_RD_ADDR,
   input  logic                     BUS_REQ,
   input  logic                     BUS_DONE,
   output logic [SELW-1:0]          EX_FORWARD_A,
   output logic [SELW-1:0]          EX_FORWARD_B,
   output logic                     ID_FORWARD_A,
   output logic                     ID_FORWARD_B,
   output logic [NUM_STAGES-2:0]    STALL,
   output logic [NUM_STAGES-2:0]    FLUSH,
   output logic                     BUS_TIMEOUT,
   output logic                     REDIRECT_PENDING,
   output logic [2**AW-1:0]         SB_BUSY
);

   localparam int NB = NUM_STAGES - 1;

   typedef enum logic [1:0] {
      BUS_IDLE  = 2'd0,
      BUS_WAIT  = 2'd1,
      BUS_ABORT = 2'd2
   } bus_state_t;

   bus_state_t        state_q, state_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              timeout_d;
   logic              pending_d;
   logic [2**AW-1:0]  sb_d;
   logic              load_use;
   logic              sb_hazard;
   logic              hazard;
   logic              bus_stall;
   logic [AW-1:0]     ex_rd_addr;
   logic              unused_inputs;

   // Only some stages feed each decision; the rest of the per-stage buses are
   // carried for a uniform interface.
   assign unused_inputs = ^{PIPE_RD_ADDR, PIPE_RD_WE, PIPE_IS_LOAD, PIPE_TRAP_VALID};

   assign ex_rd_addr = PIPE_RD_ADDR[2*AW +: AW];

   // x0 is hardwired zero, so it never matches a producer.
   function automatic logic rd_match(input int s, input logic [AW-1:0] r);
      return PIPE_RD_WE[s] && (PIPE_RD_ADDR[s*AW +: AW] == r) && (r != '0);
   endfunction

   // Forwarding selects: scan oldest to youngest so the youngest match wins.
   always_comb begin
      EX_FORWARD_A = '0;
      EX_FORWARD_B = '0;
      for (int s = NUM_STAGES - 1; s >= 3; s--) begin
         if (rd_match(s, EX_RS1_ADDR)) EX_FORWARD_A = SELW'(s);
         if (rd_match(s, EX_RS2_ADDR)) EX_FORWARD_B = SELW'(s);
      end
      ID_FORWARD_A = rd_match(NUM_STAGES - 1, ID_RS1_ADDR);
      ID_FORWARD_B = rd_match(NUM_STAGES - 1, ID_RS2_ADDR);
   end

   // Load-use across every stage whose load data is not yet forwardable,
   // plus RAW/WAW against pending MUL/DIV results.
   always_comb begin
      load_use = 1'b0;
      for (int s = 2; s < LOAD_READY_STAGE; s++) begin
         if (PIPE_IS_LOAD[s] && (rd_match(s, ID_RS1_ADDR) || rd_match(s, ID_RS2_ADDR)))
            load_use = 1'b1;
      end
      sb_hazard = SB_BUSY[ID_RS1_ADDR] | SB_BUSY[ID_RS2_ADDR] |
                  (ID_RD_WE & SB_BUSY[ID_RD_ADDR]);
      hazard    = load_use | sb_hazard;
   end

   assign bus_stall = BUS_REQ & ~BUS_DONE & (state_q != BUS_ABORT);

   // Stall/flush vectors; a redirect that cannot flush ID/EX yet is latched.
   always_comb begin
      STALL = '0;
      FLUSH = '0;
      for (int b = 0; b < NB; b++) begin
         if (b <= BUS_STAGE) STALL[b] = bus_stall;
      end
      if (hazard) begin
         STALL[0] = 1'b1;
         if (!STALL[1]) FLUSH[1] = 1'b1;
      end
      for (int t = 1; t < NUM_STAGES; t++) begin
         if (PIPE_TRAP_VALID[t]) begin
            for (int b = 0; b < t; b++) FLUSH[b] = 1'b1;
         end
      end
      if (EX_IS_PC_REDIRECT || REDIRECT_PENDING) begin
         FLUSH[0] = 1'b1;
         if (!STALL[1]) FLUSH[1] = 1'b1;
      end
      pending_d = STALL[1] ? (REDIRECT_PENDING | EX_IS_PC_REDIRECT) : 1'b0;
   end

   // Scoreboard next value; an issue to the same register as a completion wins.
   always_comb begin
      sb_d = SB_BUSY;
      if (MD_DONE) sb_d[MD_RD_ADDR] = 1'b0;
      if (MD_ISSUE && !STALL[2] && (ex_rd_addr != '0)) sb_d[ex_rd_addr] = 1'b1;
      sb_d[0] = 1'b0;
   end

   // Bus FSM next state; watchdog is a down-counter loaded on entry to WAIT.
   always_comb begin
      state_d   = state_q;
      wdog_d    = wdog_q;
      timeout_d = 1'b0;
      case (state_q)
         BUS_IDLE: begin
            if (BUS_REQ && !BUS_DONE) begin
               state_d = BUS_WAIT;
               wdog_d  = WDOG_W'(WDOG_LIMIT - 1);
            end
         end
         BUS_WAIT: begin
            if (BUS_DONE || !BUS_REQ) begin
               state_d = BUS_IDLE;
               wdog_d  = '0;
            end else if (wdog_q == '0) begin
               state_d   = BUS_ABORT;
               wdog_d    = '0;
               timeout_d = 1'b1;
            end else begin
               wdog_d = wdog_q - 1'b1;
            end
         end
         BUS_ABORT: begin
            if (!BUS_REQ) state_d = BUS_IDLE;
         end
         default: begin
            state_d = BUS_IDLE;
            wdog_d  = '0;
         end
      endcase
   end

   // State registers: FSM, watchdog, timeout pulse, redirect latch, scoreboard.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q          <= BUS_IDLE;
         wdog_q           <= '0;
         BUS_TIMEOUT      <= 1'b0;
         REDIRECT_PENDING <= 1'b0;
         SB_BUSY          <= '0;
      end else begin
         state_q          <= state_d;
         wdog_q           <= wdog_d;
         BUS_TIMEOUT      <= timeout_d;
         REDIRECT_PENDING <= pending_d;
         SB_BUSY          <= sb_d;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (5 stages, AW=5, watchdog limit 4).
module tb_pipeline_ctrl;

   localparam int NS   = 5;
   localparam int AW   = 5;
   localparam int SELW = 3;
   localparam int LIM  = 4;

   localparam int O_FWDA  = 0;
   localparam int O_FWDB  = 1;
   localparam int O_IDA   = 2;
   localparam int O_IDB   = 3;
   localparam int O_STALL = 4;
   localparam int O_FLUSH = 5;
   localparam int O_TMO   = 6;
   localparam int O_PEND  = 7;
   localparam int O_SB    = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [AW-1:0]    id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic             id_rd_we;
   logic [AW-1:0]    ex_rs1_addr, ex_rs2_addr;
   logic [NS*AW-1:0] pipe_rd_addr;
   logic [NS-1:0]    pipe_rd_we, pipe_is_load, pipe_trap_valid;
   logic             ex_is_pc_redirect, md_issue, md_done;
   logic [AW-1:0]    md_rd_addr;
   logic             bus_req, bus_done;
   logic [SELW-1:0]  ex_forward_a, ex_forward_b;
   logic             id_forward_a, id_forward_b;
   logic [NS-2:0]    stall, flush;
   logic             bus_timeout, redirect_pending;
   logic [2**AW-1:0] sb_busy;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_mis = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(
      .NUM_STAGES(NS), .AW(AW), .BUS_STAGE(3), .LOAD_READY_STAGE(4),
      .WDOG_W(8), .WDOG_LIMIT(LIM)
   ) dut (
      .CLK(clk), .RST(rst),
      .ID_RS1_ADDR(id_rs1_addr), .ID_RS2_ADDR(id_rs2_addr),
      .ID_RD_ADDR(id_rd_addr), .ID_RD_WE(id_rd_we),
      .EX_RS1_ADDR(ex_rs1_addr), .EX_RS2_ADDR(ex_rs2_addr),
      .PIPE_RD_ADDR(pipe_rd_addr), .PIPE_RD_WE(pipe_rd_we),
      .PIPE_IS_LOAD(pipe_is_load), .PIPE_TRAP_VALID(pipe_trap_valid),
      .EX_IS_PC_REDIRECT(ex_is_pc_redirect),
      .MD_ISSUE(md_issue), .MD_DONE(md_done), .MD_RD_ADDR(md_rd_addr),
      .BUS_REQ(bus_req), .BUS_DONE(bus_done),
      .EX_FORWARD_A(ex_forward_a), .EX_FORWARD_B(ex_forward_b),
      .ID_FORWARD_A(id_forward_a), .ID_FORWARD_B(id_forward_b),
      .STALL(stall), .FLUSH(flush),
      .BUS_TIMEOUT(bus_timeout), .REDIRECT_PENDING(redirect_pending),
      .SB_BUSY(sb_busy)
   );

   task automatic idle_inputs();
      id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0; id_rd_we = 1'b0;
      ex_rs1_addr = '0; ex_rs2_addr = '0;
      pipe_rd_addr = '0; pipe_rd_we = '0; pipe_is_load = '0; pipe_trap_valid = '0;
      ex_is_pc_redirect = 1'b0; md_issue = 1'b0; md_done = 1'b0; md_rd_addr = '0;
      bus_req = 1'b0; bus_done = 1'b0;
   endtask

   task automatic set_stage(input int s, input logic [AW-1:0] rd, input logic we,
                            input logic ld);
      pipe_rd_addr[s*AW +: AW] = rd;
      pipe_rd_we[s]            = we;
      pipe_is_load[s]          = ld;
   endtask

   task automatic push(input int sel, input logic [31:0] v, input string tag);
      exp_q.push_back('{tag, sel, v});
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         O_FWDA:  return 32'(ex_forward_a);
         O_FWDB:  return 32'(ex_forward_b);
         O_IDA:   return 32'(id_forward_a);
         O_IDB:   return 32'(id_forward_b);
         O_STALL: return 32'(stall);
         O_FLUSH: return 32'(flush);
         O_TMO:   return 32'(bus_timeout);
         O_PEND:  return 32'(redirect_pending);
         O_SB:    return 32'(sb_busy);
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Inputs change on the falling edge; outputs are compared 2 time units later.
   task automatic sample();
      exp_t        e;
      logic [31:0] obs;
      #2;
      while (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         obs = observe(e.sel);
         n_cmp++;
         assert (obs === e.exp)
         else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      push(O_STALL, 0, "rst_stall"); push(O_FLUSH, 0, "rst_flush");
      push(O_TMO, 0, "rst_timeout"); push(O_PEND, 0, "rst_pending");
      push(O_SB, 0, "rst_sb"); push(O_FWDA, 0, "rst_fwd_a");
      push(O_IDA, 0, "rst_id_fwd_a");
      sample();
      @(negedge clk); rst = 1'b0;

      // forwarding
      step(); set_stage(3, 5, 1, 0); set_stage(4, 6, 1, 0);
      ex_rs1_addr = 5; ex_rs2_addr = 6; id_rs1_addr = 6; id_rs2_addr = 5;
      push(O_FWDA, 3, "fwd_a_s3"); push(O_FWDB, 4, "fwd_b_s4");
      push(O_IDA, 1, "id_fwd_a_last"); push(O_IDB, 0, "id_fwd_b_none");
      push(O_STALL, 0, "fwd_no_stall"); push(O_FLUSH, 0, "fwd_no_flush");
      sample();

      step(); set_stage(3, 5, 1, 0); set_stage(4, 5, 1, 0);
      ex_rs1_addr = 5; ex_rs2_addr = 5;
      push(O_FWDA, 3, "fwd_a_youngest"); push(O_FWDB, 3, "fwd_b_youngest");
      sample();

      step(); set_stage(3, 0, 1, 0); set_stage(4, 0, 1, 0);
      push(O_FWDA, 0, "fwd_x0"); push(O_IDA, 0, "id_fwd_x0");
      sample();

      step(); set_stage(2, 5, 1, 0); set_stage(3, 5, 0, 0); set_stage(4, 5, 0, 0);
      ex_rs1_addr = 5; id_rs2_addr = 5;
      push(O_FWDA, 0, "fwd_we_low_and_ex"); push(O_IDB, 0, "id_fwd_we_low");
      push(O_STALL, 0, "non_load_no_stall");
      sample();

      // load-use
      step(); set_stage(2, 7, 1, 1); id_rs2_addr = 7;
      push(O_STALL, 4'b0001, "lu_ex_stall"); push(O_FLUSH, 4'b0010, "lu_ex_flush");
      sample();
      step(); set_stage(3, 7, 1, 1); id_rs2_addr = 7;
      push(O_STALL, 4'b0001, "lu_mem_stall"); push(O_FLUSH, 4'b0010, "lu_mem_flush");
      sample();
      step(); set_stage(4, 7, 1, 1); id_rs2_addr = 7;
      push(O_STALL, 0, "lu_ready_no_stall"); push(O_IDB, 1, "lu_ready_id_fwd");
      sample();
      step(); set_stage(2, 0, 1, 1);
      push(O_STALL, 0, "lu_x0_no_stall");
      sample();

      // MUL/DIV scoreboard
      step(); set_stage(2, 9, 1, 0); md_issue = 1'b1;
      push(O_SB, 0, "sb_issue_not_yet"); push(O_STALL, 0, "sb_issue_no_stall");
      sample();
      step(); id_rs1_addr = 9;
      push(O_SB, 32'h200, "sb_set9"); push(O_STALL, 4'b0001, "sb_raw_stall");
      push(O_FLUSH, 4'b0010, "sb_raw_flush");
      sample();
      step(); id_rd_addr = 9; id_rd_we = 1'b1;
      push(O_STALL, 4'b0001, "sb_waw_stall");
      sample();
      step(); id_rd_addr = 9;
      push(O_STALL, 0, "sb_waw_we_low");
      sample();
      step(); id_rs2_addr = 9; md_done = 1'b1; md_rd_addr = 9;
      md_issue = 1'b1; set_stage(2, 9, 1, 0);
      push(O_STALL, 4'b0001, "sb_reissue_stall"); push(O_SB, 32'h200, "sb_reissue_busy");
      sample();
      step(); id_rs2_addr = 9; md_done = 1'b1; md_rd_addr = 9;
      push(O_SB, 32'h200, "sb_set_wins"); push(O_STALL, 4'b0001, "sb_still_stall");
      sample();
      step(); id_rs2_addr = 9;
      push(O_SB, 0, "sb_cleared"); push(O_STALL, 0, "sb_released");
      sample();
      step(); md_issue = 1'b1; set_stage(2, 0, 1, 0);
      sample();
      step();
      push(O_SB, 0, "sb_x0_ignored");
      sample();

      // bus wait with watchdog expiry
      step(); bus_req = 1'b1;
      push(O_STALL, 4'b1111, "bus_idle_stall"); push(O_TMO, 0, "bus_idle_tmo");
      sample();
      for (int i = 1; i <= LIM; i++) begin
         step(); bus_req = 1'b1;
         if (i == 1) begin
            md_issue = 1'b1; set_stage(2, 12, 1, 0);
         end
         if (i == 2) push(O_SB, 0, "sb_issue_blocked_by_stall");
         push(O_STALL, 4'b1111, $sformatf("bus_wait_stall_%0d", i));
         push(O_TMO, 0, $sformatf("bus_wait_tmo_%0d", i));
         sample();
      end
      step(); bus_req = 1'b1;
      push(O_STALL, 0, "bus_abort_stall"); push(O_TMO, 1, "bus_timeout_pulse");
      sample();
      step(); bus_req = 1'b1;
      push(O_STALL, 0, "bus_abort_hold"); push(O_TMO, 0, "bus_timeout_one_cycle");
      sample();
      step();
      push(O_STALL, 0, "bus_abort_exit");
      sample();

      // redirect deferred by a bus stall
      step(); bus_req = 1'b1; ex_is_pc_redirect = 1'b1;
      push(O_STALL, 4'b1111, "rd_bus_stall"); push(O_FLUSH, 4'b0001, "rd_flush_if_only");
      push(O_PEND, 0, "rd_pend_not_yet");
      sample();
      step(); bus_req = 1'b1;
      push(O_PEND, 1, "rd_pending"); push(O_FLUSH, 4'b0001, "rd_pend_flush_if");
      sample();
      step(); bus_req = 1'b1; bus_done = 1'b1;
      push(O_STALL, 0, "rd_done_no_stall"); push(O_FLUSH, 4'b0011, "rd_pend_flush_idex");
      push(O_PEND, 1, "rd_pend_until_edge");
      sample();
      step();
      push(O_PEND, 0, "rd_pend_cleared"); push(O_FLUSH, 0, "rd_flush_done");
      sample();
      step(); ex_is_pc_redirect = 1'b1;
      push(O_FLUSH, 4'b0011, "rd_direct_flush");
      sample();
      step();
      push(O_PEND, 0, "rd_direct_no_pend");
      sample();

      // traps
      step(); set_stage(2, 7, 1, 1); id_rs1_addr = 7; pipe_trap_valid = 5'b01000;
      push(O_FLUSH, 4'b0111, "trap3_with_hazard"); push(O_STALL, 4'b0001, "trap3_stall");
      sample();
      step(); pipe_trap_valid = 5'b00010;
      push(O_FLUSH, 4'b0001, "trap1_flush");
      sample();
      step(); pipe_trap_valid = 5'b10001;
      push(O_FLUSH, 4'b1111, "trap4_flush");
      sample();

      // asynchronous reset in the middle of a bus wait
      step(); set_stage(2, 9, 1, 0); md_issue = 1'b1;
      sample();
      step(); bus_req = 1'b1; ex_is_pc_redirect = 1'b1;
      sample();
      step(); bus_req = 1'b1;
      push(O_PEND, 1, "mid_pend_set"); push(O_SB, 32'h200, "mid_sb_set");
      sample();
      step(); bus_req = 1'b1; rst = 1'b1;
      push(O_SB, 0, "arst_sb"); push(O_PEND, 0, "arst_pend");
      push(O_STALL, 4'b1111, "arst_idle_stall"); push(O_TMO, 0, "arst_tmo");
      sample();
      step(); bus_req = 1'b1; rst = 1'b0;
      push(O_STALL, 4'b1111, "post_rst_stall");
      sample();
      for (int i = 1; i <= LIM; i++) begin
         step(); bus_req = 1'b1;
         push(O_TMO, 0, $sformatf("post_rst_tmo_%0d", i));
         sample();
      end
      step(); bus_req = 1'b1;
      push(O_TMO, 1, "post_rst_full_count"); push(O_STALL, 0, "post_rst_abort");
      sample();
      step();
      sample();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
